// File: rtl/param_acc_alu.sv
// Parametrised accumulator ALU: single-cycle arithmetic/logic ops and an
// iterative one-bit-per-clock shifter behind a Start/Busy/Done handshake.
module param_acc_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             UseAcc,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Y,
  output logic             CBF,
  output logic             OVF,
  output logic             Z
);

  localparam int unsigned XW  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] M_ADD = 4'd0,  M_SUB = 4'd1,  M_INC = 4'd2,  M_DEC = 4'd3;
  localparam logic [3:0] M_AND = 4'd4,  M_OR  = 4'd5,  M_XOR = 4'd6,  M_NOT = 4'd7;
  localparam logic [3:0] M_SHL = 4'd8,  M_SHR = 4'd9,  M_SAR = 4'd10, M_ROL = 4'd11;
  localparam logic [3:0] M_ROR = 4'd12, M_PAS = 4'd13, M_CMP = 4'd14, M_CLR = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       mode_q, mode_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cbf_q, cbf_d;
  logic             ovf_q, ovf_d;
  logic             z_q, z_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] arg_b, add_y, add_res, log_res;
  logic [XW-1:0]    add_ext;
  logic             arg_c, add_ci, is_sub, add_co, add_ovf, add_cbf;

  // Shared adder: subtraction is opA + ~opB + ~borrow_in, so borrow = ~carry.
  always_comb begin : alu_comb
    arg_b  = opb_q;
    arg_c  = cin_q;
    is_sub = 1'b0;
    case (mode_q)
      M_SUB:   is_sub = 1'b1;
      M_INC:   begin arg_b = WIDTH'(1); arg_c = 1'b0; end
      M_DEC:   begin arg_b = WIDTH'(1); arg_c = 1'b0; is_sub = 1'b1; end
      M_CMP:   begin arg_c = 1'b0; is_sub = 1'b1; end
      default: ;
    endcase
    add_y   = is_sub ? ~arg_b : arg_b;
    add_ci  = is_sub ? ~arg_c : arg_c;
    add_ext = {1'b0, opa_q} + {1'b0, add_y} + XW'(add_ci);
    add_res = add_ext[WIDTH-1:0];
    add_co  = add_ext[WIDTH];
    add_ovf = add_co ^ (opa_q[MSB] ^ add_y[MSB] ^ add_res[MSB]);
    add_cbf = add_co ^ is_sub;

    case (mode_q)
      M_AND:   log_res = opa_q & opb_q;
      M_OR:    log_res = opa_q | opb_q;
      M_XOR:   log_res = opa_q ^ opb_q;
      M_NOT:   log_res = ~opa_q;
      M_PAS:   log_res = opb_q;
      default: log_res = '0;
    endcase
  end

  always_comb begin : next_comb
    state_d = state_q;
    mode_d  = mode_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cin_d   = cin_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    y_d     = y_q;
    cbf_d   = cbf_q;
    ovf_d   = ovf_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          opa_d   = UseAcc ? y_q : A;
          opb_d   = B;
          cin_d   = Cin;
          w_d     = UseAcc ? y_q : A;
          cnt_d   = B[SHW-1:0];
          last_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = (Mode >= M_SHL && Mode <= M_ROR) ? S_SHIFT : S_EXEC;
        end
      end
      S_EXEC: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        case (mode_q)
          M_ADD, M_SUB, M_INC, M_DEC: begin
            y_d   = add_res;
            cbf_d = add_cbf;
            ovf_d = add_ovf;
            z_d   = (add_res == '0);
          end
          M_CMP: begin
            cbf_d = add_cbf;
            ovf_d = add_ovf;
            z_d   = (add_res == '0);
          end
          default: begin
            y_d   = log_res;
            cbf_d = 1'b0;
            ovf_d = 1'b0;
            z_d   = (log_res == '0);
          end
        endcase
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          y_d     = w_q;
          cbf_d   = last_q;
          ovf_d   = 1'b0;
          z_d     = (w_q == '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - SHW'(1);
          case (mode_q)
            M_SHL:   begin w_d = {w_q[MSB-1:0], 1'b0};       last_d = w_q[MSB]; end
            M_SHR:   begin w_d = {1'b0, w_q[MSB:1]};         last_d = w_q[0];   end
            M_SAR:   begin w_d = {w_q[MSB], w_q[MSB:1]};     last_d = w_q[0];   end
            M_ROL:   begin w_d = {w_q[MSB-1:0], w_q[MSB]};   last_d = w_q[MSB]; end
            default: begin w_d = {w_q[0], w_q[MSB:1]};       last_d = w_q[0];   end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      w_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      y_q     <= '0;
      cbf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      z_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cin_q   <= cin_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      y_q     <= y_d;
      cbf_q   <= cbf_d;
      ovf_q   <= ovf_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Y    = y_q;
  assign CBF  = cbf_q;
  assign OVF  = ovf_q;
  assign Z    = z_q;

endmodule
